serial_adder_ctrl: RTL and testbench

//  Sequencer that adds two WIDTH-bit operands using one 4-bit ripple-carry slice, processing
//  one nibble per clock, LSB nibble first. The carry is registered between nibbles.

---
 rtl/serial_adder_ctrl_if.sv | 25 ++
 rtl/serial_adder_ctrl.sv | 127 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// The producer/consumer side uses master; the adder uses slave.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Nibble-serial adder: one 4-bit ripple slice reused NSLICE times per add,
// carry held in a flop between passes, valid/ready on both ends.
module serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus,
  output logic                busy
);
  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic [4:0]       slice_s;
  logic [WIDTH+3:0] shift_s;

  // The single 4-bit slice; its result enters the partial sum from the top.
  assign slice_s = {1'b0, op_a_q[3:0]} + {1'b0, op_b_q[3:0]} + {4'd0, carry_q};
  assign shift_s = {slice_s[3:0], psum_q};

  // Next-state and datapath updates for the accept / pass / drain sequence.
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    psum_d   = psum_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          op_a_d  = bus.a;
          op_b_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          psum_d  = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        op_a_d  = op_a_q >> 3'd4;
        op_b_d  = op_b_q >> 3'd4;
        psum_d  = shift_s[WIDTH+3:4];
        carry_d = slice_s[4];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NSLICE - 1)) begin
          sum_d   = shift_s[WIDTH+3:4];
          cout_d  = slice_s[4];
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake flags are registered copies of the state being entered.
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State, datapath and output registers; reset aborts any add in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      psum_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      psum_q      <= psum_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: a 16-bit and a 4-bit instance, each result
// checked against plain (WIDTH+1)-bit arithmetic a+b+cin.
module tb_serial_adder_ctrl;
  logic clk;
  logic rst_n;
  logic busy16;
  logic busy4;
  int   n_tests;
  int   n_fail;

  serial_adder_ctrl_if #(.WIDTH(16)) i16 ();
  serial_adder_ctrl_if #(.WIDTH(4))  i4 ();

  serial_adder_ctrl #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16), .busy(busy16));
  serial_adder_ctrl #(.WIDTH(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(i4),  .busy(busy4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full 16-bit transaction; returns the result, edges from accept to out_valid, and whether both waits completed.
  task automatic run_add16(input logic [15:0] a, input logic [15:0] b, input logic c,
                           output logic [15:0] s, output logic co, output int lat, output bit ok);
    int w;
    ok = 1'b1;
    lat = 0;
    w = 0;
    i16.a = a; i16.b = b; i16.cin = c; i16.in_valid = 1'b1; i16.out_ready = 1'b0;
    while (i16.in_ready !== 1'b1 && w < 20) begin tick(); w++; end
    if (i16.in_ready !== 1'b1) ok = 1'b0;
    tick();
    i16.in_valid = 1'b0;
    i16.a = 16'($urandom); i16.b = 16'($urandom); i16.cin = 1'($urandom);
    while (i16.out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
    if (i16.out_valid !== 1'b1) ok = 1'b0;
    s = i16.sum;
    co = i16.cout;
    i16.out_ready = 1'b1;
    tick();
    i16.out_ready = 1'b0;
  endtask

  task automatic run_add4(input logic [3:0] a, input logic [3:0] b, input logic c,
                          output logic [3:0] s, output logic co, output int lat, output bit ok);
    int w;
    ok = 1'b1;
    lat = 0;
    w = 0;
    i4.a = a; i4.b = b; i4.cin = c; i4.in_valid = 1'b1; i4.out_ready = 1'b0;
    while (i4.in_ready !== 1'b1 && w < 20) begin tick(); w++; end
    if (i4.in_ready !== 1'b1) ok = 1'b0;
    tick();
    i4.in_valid = 1'b0;
    i4.a = 4'($urandom); i4.b = 4'($urandom); i4.cin = 1'($urandom);
    while (i4.out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
    if (i4.out_valid !== 1'b1) ok = 1'b0;
    s = i4.sum;
    co = i4.cout;
    i4.out_ready = 1'b1;
    tick();
    i4.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i16.in_valid = 1'b0; i16.out_ready = 1'b0; i16.a = 16'd0; i16.b = 16'd0; i16.cin = 1'b0;
    i4.in_valid = 1'b0;  i4.out_ready = 1'b0;  i4.a = 4'd0;   i4.b = 4'd0;   i4.cin = 1'b0;
    #22;
    n_tests++;
    if ({i16.out_valid, i16.in_ready, busy16, i16.cout, i16.sum} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset16: ov/ir/busy/cout/sum=%b/%b/%b/%b/%h expected 0/0/0/0/0000",
               i16.out_valid, i16.in_ready, busy16, i16.cout, i16.sum);
    end
    n_tests++;
    if ({i4.out_valid, i4.in_ready, busy4, i4.cout, i4.sum} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset4: ov/ir/busy/cout/sum=%b/%b/%b/%b/%h expected all 0",
               i4.out_valid, i4.in_ready, busy4, i4.cout, i4.sum);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (i16.in_ready !== 1'b1 || i4.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready16=%b in_ready4=%b expected 1/1", i16.in_ready, i4.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic        vc [3];
    logic [15:0] s;
    logic        co;
    logic [16:0] exp;
    int          lat;
    bit          ok;
    va[0] = 16'h0000; vb[0] = 16'h0000; vc[0] = 1'b0;
    va[1] = 16'hFFFF; vb[1] = 16'h0001; vc[1] = 1'b0;
    va[2] = 16'hFFFF; vb[2] = 16'hFFFF; vc[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_add16(va[k], vb[k], vc[k], s, co, lat, ok);
      exp = {1'b0, va[k]} + {1'b0, vb[k]} + {16'd0, vc[k]};
      n_tests++;
      if (!ok || {co, s} !== exp) begin
        n_fail++;
        $display("FAIL directed%0d: got cout=%b sum=%h (ok=%0d) expected cout=%b sum=%h",
                 k, co, s, ok, exp[16], exp[15:0]);
      end
      // out_valid is first visible after the 4th edge following the accept edge (5th cycle counting the accept cycle).
      n_tests++;
      if (lat !== 4) begin
        n_fail++;
        $display("FAIL latency%0d: got %0d edges after accept, expected 4", k, lat);
      end
    end
  endtask

  task automatic test_hold();
    int w;
    bit held_ok;
    w = 0;
    held_ok = 1'b1;
    i16.a = 16'h1234; i16.b = 16'h4321; i16.cin = 1'b1; i16.in_valid = 1'b1; i16.out_ready = 1'b0;
    while (i16.in_ready !== 1'b1 && w < 20) begin tick(); w++; end
    tick();
    // in_valid stays high with a different pair; it must not be taken until the result drains.
    i16.a = 16'h0001; i16.b = 16'h0002; i16.cin = 1'b0;
    w = 0;
    while (i16.out_valid !== 1'b1 && w < 20) begin tick(); w++; end
    for (int k = 0; k < 3; k++) begin
      if (i16.out_valid !== 1'b1 || i16.in_ready !== 1'b0 || busy16 !== 1'b1 ||
          i16.sum !== 16'h5556 || i16.cout !== 1'b0) begin
        held_ok = 1'b0;
        $display("FAIL hold_cycle%0d: ov=%b ir=%b busy=%b cout=%b sum=%h expected 1/0/1/0/5556",
                 k, i16.out_valid, i16.in_ready, busy16, i16.cout, i16.sum);
      end
      tick();
    end
    n_tests++;
    if (!held_ok) n_fail++;
    i16.out_ready = 1'b1;
    tick();
    i16.out_ready = 1'b0;
    n_tests++;
    if (i16.out_valid !== 1'b0 || i16.in_ready !== 1'b1 || i16.sum !== 16'h5556) begin
      n_fail++;
      $display("FAIL hold_release: ov=%b ir=%b sum=%h expected 0/1/5556", i16.out_valid, i16.in_ready, i16.sum);
    end
    tick();
    i16.in_valid = 1'b0;
    w = 0;
    while (i16.out_valid !== 1'b1 && w < 20) begin tick(); w++; end
    n_tests++;
    if (i16.out_valid !== 1'b1 || i16.sum !== 16'h0003 || i16.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_next_add: ov=%b cout=%b sum=%h expected 1/0/0003", i16.out_valid, i16.cout, i16.sum);
    end
    i16.out_ready = 1'b1;
    tick();
    i16.out_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int          w;
    bit          stayed_low;
    logic [15:0] a, b, s;
    logic        c, co;
    logic [16:0] exp;
    int          lat;
    bit          ok;
    w = 0;
    stayed_low = 1'b1;
    i16.a = 16'($urandom); i16.b = 16'($urandom); i16.cin = 1'($urandom); i16.in_valid = 1'b1;
    while (i16.in_ready !== 1'b1 && w < 20) begin tick(); w++; end
    tick();
    i16.in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({i16.out_valid, i16.in_ready, busy16, i16.cout, i16.sum} !== 20'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: ov/ir/busy/cout/sum=%b/%b/%b/%b/%h expected all 0",
               i16.out_valid, i16.in_ready, busy16, i16.cout, i16.sum);
    end
    #1 rst_n = 1'b1;
    tick();
    n_tests++;
    if (i16.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_ready: in_ready=%b expected 1", i16.in_ready);
    end
    for (int k = 0; k < 8; k++) begin
      if (i16.out_valid !== 1'b0 || i16.sum !== 16'h0000 || i16.cout !== 1'b0) stayed_low = 1'b0;
      tick();
    end
    n_tests++;
    if (!stayed_low) begin
      n_fail++;
      $display("FAIL midrun_abort: aborted add produced output (ov=%b sum=%h) expected no result", i16.out_valid, i16.sum);
    end
    a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
    run_add16(a, b, c, s, co, lat, ok);
    exp = {1'b0, a} + {1'b0, b} + {16'd0, c};
    n_tests++;
    if (!ok || {co, s} !== exp) begin
      n_fail++;
      $display("FAIL midrun_next_add: got cout=%b sum=%h expected cout=%b sum=%h", co, s, exp[16], exp[15:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] expq[$];
    logic [16:0] exp;
    int acc, res, cyc, last_acc;
    acc = 0; res = 0; cyc = 0; last_acc = -1;
    i16.out_ready = 1'b1;
    while ((acc < 200 || res < 200) && cyc < 3000) begin
      if (i16.out_valid === 1'b1) begin
        n_tests++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_spurious: result %b/%h with nothing outstanding", i16.cout, i16.sum);
        end else begin
          exp = expq.pop_front();
          if ({i16.cout, i16.sum} !== exp) begin
            n_fail++;
            $display("FAIL b2b_result%0d: got cout=%b sum=%h expected cout=%b sum=%h",
                     res, i16.cout, i16.sum, exp[16], exp[15:0]);
          end
        end
        res++;
      end
      i16.a = 16'($urandom); i16.b = 16'($urandom); i16.cin = 1'($urandom);
      i16.in_valid = (acc < 200);
      if (i16.in_ready === 1'b1 && acc < 200) begin
        expq.push_back({1'b0, i16.a} + {1'b0, i16.b} + {16'd0, i16.cin});
        if (last_acc >= 0) begin
          n_tests++;
          if (cyc - last_acc !== 6) begin
            n_fail++;
            $display("FAIL b2b_spacing%0d: got %0d cycles between accepts expected 6", acc, cyc - last_acc);
          end
        end
        last_acc = cyc;
        acc++;
      end
      tick();
      cyc++;
    end
    i16.in_valid = 1'b0;
    i16.out_ready = 1'b0;
    n_tests++;
    if (acc != 200 || res != 200) begin
      n_fail++;
      $display("FAIL b2b_timeout: accepted %0d results %0d expected 200/200", acc, res);
    end
    tick();
  endtask

  task automatic test_width4();
    logic [3:0] a, b, s;
    logic       c, co;
    logic [4:0] exp;
    int         lat;
    bit         ok;
    run_add4(4'hF, 4'h1, 1'b1, s, co, lat, ok);
    n_tests++;
    if (!ok || s !== 4'h1 || co !== 1'b1) begin
      n_fail++;
      $display("FAIL w4_directed: got cout=%b sum=%h expected cout=1 sum=1", co, s);
    end
    // Single pass: out_valid is visible after the first edge following accept (2 cycles counting the accept cycle).
    n_tests++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL w4_latency: got %0d edges after accept expected 1", lat);
    end
    for (int k = 0; k < 8; k++) begin
      a = 4'($urandom); b = 4'($urandom); c = 1'($urandom);
      run_add4(a, b, c, s, co, lat, ok);
      exp = {1'b0, a} + {1'b0, b} + {4'd0, c};
      n_tests++;
      if (!ok || {co, s} !== exp) begin
        n_fail++;
        $display("FAIL w4_random%0d: %h+%h+%b got cout=%b sum=%h expected cout=%b sum=%h",
                 k, a, b, c, co, s, exp[4], exp[3:0]);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_directed();
    test_hold();
    test_reset_midrun();
    test_back_to_back();
    test_width4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
